// File: rtl/noc_pkg.sv
// noc_pkg: node address table, packet layout, FSM states and LFSR taps
// shared by the mesh traffic generator and its LFSR.
package noc_pkg;

    localparam int PKT_ADDR_W = 4;
    localparam int PKT_DATA_W = 24;

    // Galois mask for x^32 + x^22 + x^2 + x + 1 (right-shifting form)
    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

    // PE0..PE8 then memory; unused slots are 4'b1111 so they never match a real node
    localparam logic [3:0] NODE_ADDR [16] = '{
        4'b0000, 4'b0100, 4'b1000, 4'b0001, 4'b0101, 4'b1001, 4'b0010, 4'b0110,
        4'b1010, 4'b1101, 4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b1111
    };

    typedef struct packed {
        logic                  filt;
        logic [PKT_ADDR_W-1:0] dst;
        logic [PKT_ADDR_W-1:0] src;
        logic [PKT_DATA_W-1:0] data;
    } packet_t;

    typedef enum logic [2:0] {
        S_IDLE, S_PICK_SRC, S_PICK_DST, S_PREP, S_SEND, S_GAP, S_DRAIN, S_DONE
    } state_t;

    function automatic logic in_table(input logic [3:0] a, input int n);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < 16; i++)
            hit = hit | ((i < n) && (NODE_ADDR[i] == a));
        return hit;
    endfunction

endpackage

// File: rtl/noc_lfsr32.sv
// noc_lfsr32: 32-bit Galois LFSR, loaded with the seed in reset and
// stepped once per enabled cycle.
module noc_lfsr32
    import noc_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] i_seed,
    input  logic        i_en,
    output logic [31:0] o_value
);

    logic [31:0] r_lfsr;

    always_ff @(posedge clk) begin
        if (!rst_n)
            r_lfsr <= i_seed;
        else if (i_en)
            r_lfsr <= r_lfsr[0] ? ((r_lfsr >> 1) ^ LFSR_TAPS) : (r_lfsr >> 1);
    end

    assign o_value = r_lfsr;

endmodule

// File: rtl/noc_traffic_gen.sv
// noc_traffic_gen: random packet source over valid/ready plus a checker
// for packets returned by the mesh; repeatable from SEED.
module noc_traffic_gen
    import noc_pkg::*;
#(
    parameter int          ADDR_W     = 4,
    parameter int          DATA_W     = 24,
    parameter int          WIDTH      = 1 + 2 * ADDR_W + DATA_W,
    parameter int          NUM_NODES  = 10,
    parameter int          NUM_PKTS   = 50,
    parameter int          GAP_CYCLES = 32,
    parameter int          DATA_MOD_W = 10,
    parameter int          TIMEOUT    = 1024,
    parameter logic [31:0] SEED       = 32'hACE1_2024
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    output logic             o_tx_valid,
    output logic [WIDTH-1:0] o_tx_data,
    input  logic             i_tx_ready,
    input  logic             i_rx_valid,
    input  logic [WIDTH-1:0] i_rx_data,
    output logic             o_rx_ready,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_timeout,
    output logic [15:0]      o_sent_cnt,
    output logic [15:0]      o_rcvd_cnt,
    output logic [15:0]      o_err_cnt
);

    state_t             r_state;
    logic [ADDR_W-1:0]  r_src;
    logic [ADDR_W-1:0]  r_dst;
    logic [31:0]        r_wait;
    logic               r_tx_valid;
    logic [WIDTH-1:0]   r_tx_data;
    logic               r_rx_ready;
    logic               r_busy;
    logic               r_done;
    logic               r_timeout;
    logic [15:0]        r_sent;
    logic [15:0]        r_rcvd;
    logic [15:0]        r_err;

    logic [31:0]        w_lfsr;
    logic               w_lfsr_en;
    logic [3:0]         w_idx;
    logic               w_idx_ok;
    logic [3:0]         w_node;
    logic [DATA_W-1:0]  w_data;
    logic               w_tx_acc;
    logic               w_rx;
    logic [ADDR_W-1:0]  w_rx_dst;
    logic [ADDR_W-1:0]  w_rx_src;
    logic               w_rx_bad;
    logic [15:0]        w_sent_nx;
    logic [15:0]        w_rcvd_nx;
    logic [15:0]        w_err_nx;
    logic               w_unused;

    noc_lfsr32 u_lfsr (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_seed  (SEED),
        .i_en    (w_lfsr_en),
        .o_value (w_lfsr)
    );

    assign w_lfsr_en = (r_state == S_PICK_SRC) || (r_state == S_PICK_DST) || (r_state == S_PREP);
    assign w_idx     = w_lfsr[3:0];
    assign w_idx_ok  = 32'(w_idx) < 32'(NUM_NODES);
    assign w_node    = NODE_ADDR[w_idx];
    assign w_data    = DATA_W'(w_lfsr[DATA_MOD_W-1:0]);

    assign w_tx_acc  = r_tx_valid & i_tx_ready;
    assign w_rx      = i_rx_valid & r_rx_ready;
    assign w_rx_dst  = i_rx_data[DATA_W+ADDR_W +: ADDR_W];
    assign w_rx_src  = i_rx_data[DATA_W +: ADDR_W];

    // Counters saturate; the in-flight check sees this cycle's tx accept too
    assign w_sent_nx = (w_tx_acc && r_sent != 16'hFFFF) ? r_sent + 16'd1 : r_sent;
    assign w_rcvd_nx = (w_rx && r_rcvd != 16'hFFFF) ? r_rcvd + 16'd1 : r_rcvd;
    assign w_rx_bad  = !in_table(w_rx_dst, NUM_NODES) || !in_table(w_rx_src, NUM_NODES)
                     || (w_rx_dst == w_rx_src) || (|i_rx_data[DATA_W-1:DATA_MOD_W])
                     || (w_rcvd_nx > w_sent_nx);
    assign w_err_nx  = (w_rx && w_rx_bad && r_err != 16'hFFFF) ? r_err + 16'd1 : r_err;

    assign w_unused  = ^{i_rx_data[WIDTH-1], w_lfsr[30:DATA_MOD_W]};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_src      <= '0;
            r_dst      <= '0;
            r_wait     <= '0;
            r_tx_valid <= 1'b0;
            r_tx_data  <= '0;
            r_rx_ready <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_timeout  <= 1'b0;
            r_sent     <= '0;
            r_rcvd     <= '0;
            r_err      <= '0;
        end else begin
            r_rx_ready <= 1'b1;
            r_sent     <= w_sent_nx;
            r_rcvd     <= w_rcvd_nx;
            r_err      <= w_err_nx;
            case (r_state)
                S_IDLE, S_DONE: if (i_start) begin
                    r_sent    <= '0;
                    r_rcvd    <= '0;
                    r_err     <= '0;
                    r_done    <= 1'b0;
                    r_timeout <= 1'b0;
                    r_busy    <= 1'b1;
                    r_state   <= S_PICK_SRC;
                end
                S_PICK_SRC: if (w_idx_ok) begin
                    r_src   <= w_node;
                    r_state <= S_PICK_DST;
                end
                S_PICK_DST: if (w_idx_ok && w_node != r_src) begin
                    r_dst   <= w_node;
                    r_state <= S_PREP;
                end
                S_PREP: begin
                    r_tx_data  <= {w_lfsr[31], r_dst, r_src, w_data};
                    r_tx_valid <= 1'b1;
                    r_state    <= S_SEND;
                end
                S_SEND: if (w_tx_acc) begin
                    r_tx_valid <= 1'b0;
                    r_wait     <= '0;
                    r_state    <= (w_sent_nx == 16'(NUM_PKTS)) ? S_DRAIN :
                                  (GAP_CYCLES == 0) ? S_PICK_SRC : S_GAP;
                end
                S_GAP: begin
                    r_wait <= r_wait + 32'd1;
                    if (r_wait == 32'(GAP_CYCLES - 1))
                        r_state <= S_PICK_SRC;
                end
                S_DRAIN: if (r_rcvd == r_sent || r_wait == 32'(TIMEOUT - 1)) begin
                    r_state   <= S_DONE;
                    r_busy    <= 1'b0;
                    r_done    <= 1'b1;
                    r_timeout <= r_rcvd != r_sent;
                end else begin
                    r_wait <= r_wait + 32'd1;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_tx_valid = r_tx_valid;
    assign o_tx_data  = r_tx_data;
    assign o_rx_ready = r_rx_ready;
    assign o_busy     = r_busy;
    assign o_done     = r_done;
    assign o_timeout  = r_timeout;
    assign o_sent_cnt = r_sent;
    assign o_rcvd_cnt = r_rcvd;
    assign o_err_cnt  = r_err;

endmodule

// File: doc/noc_traffic_gen.md
Name: noc_traffic_gen

Overview:
Synthesisable, clocked packet source and sink checker for the 3x3 mesh NoC. It generates a configurable number of random packets between legal node addresses (PE0–PE8 and memory), never with src == dst. Packets are driven over a valid/ready port and returned packets are checked. It replaces directed injection with a parametrised, repeatable, self-checking traffic engine that sits between the NoC edge adapters and the test harness.

Parameters:
ADDR_W, 4, width of source and destination address fields
DATA_W, 24, width of payload field
WIDTH, 1+2*ADDR_W+DATA_W (33), packet width
NUM_NODES, 10, entries used from NODE_ADDR table (2..16)
NUM_PKTS, 50, packets to send per run (1..65535)
GAP_CYCLES, 32, idle cycles after each accepted packet (0 allowed)
DATA_MOD_W, 10, payload low bits randomised; upper bits zero
TIMEOUT, 1024, cycles allowed after last send for outstanding packets to return
SEED, 32'hACE1_2024, LFSR reset value (must be nonzero)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
start  in  1  one-cycle pulse that starts a run (ignored unless IDLE or DONE)
tx_valid  out  1  packet valid
tx_data  out  WIDTH  packet {filt, dst, src, data}
tx_ready  in  1  downstream accept
rx_valid  in  1  returned packet valid
rx_data  in  WIDTH  returned packet
rx_ready  out  1  always 1 except in reset
busy  out  1  run in progress
done  out  1  run finished (sticky until start or reset)
timeout  out  1  done reached through TIMEOUT expiry
sent_cnt  out  16  packets accepted on tx
rcvd_cnt  out  16  packets accepted on rx
err_cnt  out  16  rx packets failing checks

Behaviour:
- One clock; reset is synchronous and active-low (rst_n sampled on the rising edge of clk). Reset clears all outputs to 0, loads LFSR = SEED, and sets state IDLE. rx_ready is 0 during reset and 1 from the first cycle after reset.
- LFSR: 32-bit Galois, taps x^32+x^22+x^2+x+1, advances exactly once per cycle in PICK_SRC, PICK_DST and PREP.
- FSM: IDLE -> (start) PICK_SRC -> PICK_DST -> PREP -> SEND -> GAP -> PICK_SRC | DRAIN -> DONE.
  - PICK_SRC: idx = lfsr[3:0]. If idx >= NUM_NODES, reject and retry next cycle; otherwise src = NODE_ADDR[idx].
  - PICK_DST: same rejection, plus reject if NODE_ADDR[idx] == src.
  - PREP: data = zero-extend(lfsr[DATA_MOD_W-1:0]); filt = lfsr[31]. Register tx_data.
  - SEND: tx_valid = 1. tx_data is held stable until tx_valid & tx_ready. On accept, sent_cnt++. Go to GAP, or to DRAIN if sent_cnt reaches NUM_PKTS.
  - GAP: count GAP_CYCLES. With GAP_CYCLES = 0, go directly to PICK_SRC.
  - DRAIN: wait until rcvd_cnt == sent_cnt -> DONE with timeout = 0. If the drain counter reaches TIMEOUT first -> DONE with timeout = 1.
  - DONE: done = 1 and busy = 0. start clears all counters, done and timeout, and begins a new run without reseeding the LFSR.
- busy = 1 in every state except IDLE and DONE.
- Rx check, active in every state: on rx_valid, rcvd_cnt++. err_cnt++ if any of:
  - dst is not in NODE_ADDR[0..NUM_NODES-1],
  - src is not in NODE_ADDR[0..NUM_NODES-1],
  - src == dst,
  - data bits above DATA_MOD_W are nonzero,
  - rcvd_cnt would exceed sent_cnt.
- Counters saturate at 16'hFFFF.
- Simultaneous tx accept and rx in the same cycle: both counters update in that cycle, and the in-flight comparison uses the updated values.
- start while busy: ignored.
- Reset mid-run: tx_valid is 0 on the next cycle; state and LFSR return to reset values, so the packet sequence is identical after reset.

Decomposition:
- Package noc_pkg:
  - NODE_ADDR[0:15] constant: 0000, 0100, 1000, 0001, 0101, 1001, 0010, 0110, 1010, 1101 (PE0–PE8, memory), rest 1111.
  - packet_t struct {filt, dst, src, data}.
  - state_t enum.
  - LFSR_TAPS constant.
- Sub-module noc_lfsr32 (seed, enable, value).

Test Plan:
- rst_n low for 3 cycles -> all counters, tx_valid, done, busy = 0; rx_ready = 0, then 1 after release.
- NUM_PKTS=4, GAP_CYCLES=2, tx_ready=1, rx looped from tx with 5-cycle delay -> 4 packets, each src != dst, addresses in table; done=1, timeout=0, sent=rcvd=4, err=0.
- tx_ready held low for 10 cycles during SEND -> tx_valid stays 1, tx_data bit-identical, sent_cnt unchanged until ready rises.
- rx packet with dst=4'b1111 (or src=dst=4'b0101) -> err_cnt=1, rcvd_cnt increments.
- NUM_PKTS=2, TIMEOUT=100, no rx -> done and timeout both rise exactly 100 cycles after the 2nd accept.
- Reset asserted mid-SEND of packet 3, then start -> first packet equals the first packet of a fresh run (same SEED).
